// File: rtl/ff_bank_cfg.sv
// rtl/ff_bank_cfg.sv - configurable D/T/JK/SR storage-cell bank with change detection and counters
module ff_bank_cfg #(
    parameter int               WIDTH   = 4,
    parameter int               CNT_W   = 4,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     en,
    input  logic                     clr,
    input  logic [1:0]               mode,
    input  logic [WIDTH-1:0]         data_in,
    input  logic [WIDTH-1:0]         aux_in,
    output logic [WIDTH-1:0]         data_out,
    output logic [WIDTH-1:0]         chg_pulse,
    output logic [WIDTH*CNT_W-1:0]   chg_cnt,
    output logic                     sr_err,
    output logic                     sat_flag
);

    localparam logic [1:0]       MODE_D  = 2'b00;
    localparam logic [1:0]       MODE_T  = 2'b01;
    localparam logic [1:0]       MODE_JK = 2'b10;
    localparam logic [1:0]       MODE_SR = 2'b11;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0]       r_q;
    logic [WIDTH-1:0]       r_chg;
    logic [WIDTH*CNT_W-1:0] r_cnt;
    logic                   r_sr_err;
    logic                   r_sat;

    logic [WIDTH-1:0]       w_next;
    logic [WIDTH-1:0]       w_chg;
    logic [WIDTH*CNT_W-1:0] w_cnt_next;
    logic [CNT_W-1:0]       w_cell_cnt;
    logic                   w_reach;
    logic                   w_sr_err;

    always_comb begin
        w_next = r_q;
        for (int i = 0; i < WIDTH; i++) begin
            case (mode)
                MODE_D:  w_next[i] = data_in[i];
                MODE_T:  w_next[i] = r_q[i] ^ data_in[i];
                MODE_JK: begin
                    case ({data_in[i], aux_in[i]})
                        2'b01:   w_next[i] = 1'b0;
                        2'b10:   w_next[i] = 1'b1;
                        2'b11:   w_next[i] = ~r_q[i];
                        default: w_next[i] = r_q[i];
                    endcase
                end
                default: begin
                    // S=R=1 is illegal and holds; it is flagged via sr_err instead
                    case ({data_in[i], aux_in[i]})
                        2'b10:   w_next[i] = 1'b1;
                        2'b01:   w_next[i] = 1'b0;
                        default: w_next[i] = r_q[i];
                    endcase
                end
            endcase
        end
        if (!en) begin
            w_next = r_q;
        end
    end

    assign w_chg    = w_next ^ r_q;
    assign w_sr_err = en && (mode == MODE_SR) && (|(data_in & aux_in));

    always_comb begin
        w_cnt_next = r_cnt;
        w_cell_cnt = '0;
        w_reach    = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            w_cell_cnt = r_cnt[i*CNT_W +: CNT_W];
            if (clr) begin
                w_cnt_next[i*CNT_W +: CNT_W] = '0;
            end else if (w_chg[i] && (w_cell_cnt != CNT_MAX)) begin
                w_cnt_next[i*CNT_W +: CNT_W] = w_cell_cnt + CNT_ONE;
                if ((w_cell_cnt + CNT_ONE) == CNT_MAX) begin
                    w_reach = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q      <= RST_VAL;
            r_chg    <= '0;
            r_cnt    <= '0;
            r_sr_err <= 1'b0;
            r_sat    <= 1'b0;
        end else begin
            r_q      <= w_next;
            r_chg    <= w_chg;
            r_cnt    <= w_cnt_next;
            r_sr_err <= w_sr_err;
            r_sat    <= clr ? 1'b0 : (r_sat | w_reach);
        end
    end

    assign data_out  = r_q;
    assign chg_pulse = r_chg;
    assign chg_cnt   = r_cnt;
    assign sr_err    = r_sr_err;
    assign sat_flag  = r_sat;

endmodule

// File: tb/tb_ff_bank_cfg.sv
// tb/tb_ff_bank_cfg.sv - randomized and directed self-checking bench for ff_bank_cfg
module tb_ff_bank_cfg;

    localparam int         W       = 4;
    localparam logic [3:0] RST_VAL = 4'b1010;
    localparam int         MAX_A   = 15;
    localparam int         MAX_B   = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic       clr = 1'b0;
    logic [1:0] mode = 2'b00;
    logic [3:0] data_in = '0;
    logic [3:0] aux_in = '0;

    logic [3:0]  a_dout, a_chg, b_dout, b_chg;
    logic [15:0] a_cnt;
    logic [7:0]  b_cnt;
    logic        a_sr, a_sat, b_sr, b_sat;

    int n_chk  = 0;
    int n_pass = 0;

    bit m_q   [W];
    bit m_chg [W];
    int m_ca  [W];
    int m_cb  [W];
    bit m_sr, m_sat_a, m_sat_b;

    ff_bank_cfg #(.WIDTH(4), .CNT_W(4), .RST_VAL(RST_VAL)) dut_a (
        .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .mode(mode),
        .data_in(data_in), .aux_in(aux_in), .data_out(a_dout),
        .chg_pulse(a_chg), .chg_cnt(a_cnt), .sr_err(a_sr), .sat_flag(a_sat)
    );

    ff_bank_cfg #(.WIDTH(4), .CNT_W(2), .RST_VAL(RST_VAL)) dut_b (
        .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .mode(mode),
        .data_in(data_in), .aux_in(aux_in), .data_out(b_dout),
        .chg_pulse(b_chg), .chg_cnt(b_cnt), .sr_err(b_sr), .sat_flag(b_sat)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic model_reset();
        for (int i = 0; i < W; i++) begin
            m_q[i] = RST_VAL[i];
            m_chg[i] = 0;
            m_ca[i] = 0;
            m_cb[i] = 0;
        end
        m_sr = 0;
        m_sat_a = 0;
        m_sat_b = 0;
    endtask

    task automatic model_edge();
        bit nq;
        bit j, k;
        m_sr = 0;
        for (int i = 0; i < W; i++) begin
            j = data_in[i];
            k = aux_in[i];
            nq = m_q[i];
            if (en) begin
                if (mode == 0) nq = j;
                else if (mode == 1) nq = m_q[i] ^ j;
                else if (mode == 2) begin
                    if (j && k) nq = !m_q[i];
                    else if (j) nq = 1;
                    else if (k) nq = 0;
                end else begin
                    if (j && k) m_sr = 1;
                    else if (j) nq = 1;
                    else if (k) nq = 0;
                end
            end
            m_chg[i] = (nq != m_q[i]);
            m_q[i] = nq;
            if (clr) begin
                m_ca[i] = 0;
                m_cb[i] = 0;
            end else if (m_chg[i]) begin
                m_ca[i] = (m_ca[i] + 1 > MAX_A) ? MAX_A : m_ca[i] + 1;
                m_cb[i] = (m_cb[i] + 1 > MAX_B) ? MAX_B : m_cb[i] + 1;
            end
        end
        if (clr) begin
            m_sat_a = 0;
            m_sat_b = 0;
        end else begin
            for (int i = 0; i < W; i++) begin
                if (m_ca[i] == MAX_A) m_sat_a = 1;
                if (m_cb[i] == MAX_B) m_sat_b = 1;
            end
        end
    endtask

    task automatic compare_all(input string tag);
        logic [3:0]  eq, ec;
        logic [15:0] eca;
        logic [7:0]  ecb;
        for (int i = 0; i < W; i++) begin
            eq[i] = m_q[i];
            ec[i] = m_chg[i];
            eca[i*4 +: 4] = 4'(m_ca[i]);
            ecb[i*2 +: 2] = 2'(m_cb[i]);
        end
        chk({tag, ".a_q"},   64'(a_dout), 64'(eq));
        chk({tag, ".a_chg"}, 64'(a_chg),  64'(ec));
        chk({tag, ".a_cnt"}, 64'(a_cnt),  64'(eca));
        chk({tag, ".a_sr"},  64'(a_sr),   64'(m_sr));
        chk({tag, ".a_sat"}, 64'(a_sat),  64'(m_sat_a));
        chk({tag, ".b_q"},   64'(b_dout), 64'(eq));
        chk({tag, ".b_chg"}, 64'(b_chg),  64'(ec));
        chk({tag, ".b_cnt"}, 64'(b_cnt),  64'(ecb));
        chk({tag, ".b_sr"},  64'(b_sr),   64'(m_sr));
        chk({tag, ".b_sat"}, 64'(b_sat),  64'(m_sat_b));
    endtask

    task automatic step(input string tag, input logic e, input logic c, input logic [1:0] m,
                        input logic [3:0] d, input logic [3:0] a);
        en = e;
        clr = c;
        mode = m;
        data_in = d;
        aux_in = a;
        @(posedge clk);
        model_edge();
        #1;
        compare_all(tag);
    endtask

    task automatic mid_reset();
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        model_reset();
        compare_all("rst_mid");
        chk("rst_q_const", 64'(a_dout), 64'(4'b1010));
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [0:2] t_seq;
        logic [0:4] s_sat;
        logic [1:0] s_cnt [5];
        model_reset();
        #12;
        rst_n = 1'b1;
        @(negedge clk);
        compare_all("rst_init");

        for (int n = 0; n < 6; n++)
            step("warm", 1'b1, 1'b0, 2'($urandom_range(0, 3)), 4'($urandom), 4'($urandom));
        mid_reset();
        chk("rst_cnt_const", 64'(a_cnt), 64'(0));
        chk("rst_sat_const", 64'(a_sat), 64'(0));

        // T mode toggling cell 0 from zero
        step("t_init", 1'b1, 1'b1, 2'b00, 4'b0000, 4'b0000);
        t_seq = 3'b101;
        for (int n = 0; n < 3; n++) begin
            step("t_run", 1'b1, 1'b0, 2'b01, 4'b0001, 4'b0000);
            chk("t_q0", 64'(a_dout[0]), 64'(t_seq[n]));
            chk("t_pulse0", 64'(a_chg[0]), 64'(1));
        end
        chk("t_cnt", 64'(a_cnt), 64'(16'h0003));

        // JK sequence
        step("jk_init", 1'b1, 1'b1, 2'b00, 4'b0000, 4'b0000);
        step("jk_set", 1'b1, 1'b0, 2'b10, 4'b1111, 4'b0000);
        chk("jk_set_q", 64'(a_dout), 64'(4'b1111));
        step("jk_rst", 1'b1, 1'b0, 2'b10, 4'b0000, 4'b1111);
        chk("jk_rst_q", 64'(a_dout), 64'(4'b0000));
        step("jk_tg1", 1'b1, 1'b0, 2'b10, 4'b1111, 4'b1111);
        chk("jk_tg1_q", 64'(a_dout), 64'(4'b1111));
        step("jk_tg2", 1'b1, 1'b0, 2'b10, 4'b1111, 4'b1111);
        chk("jk_tg2_q", 64'(a_dout), 64'(4'b0000));
        chk("jk_cnt", 64'(a_cnt), 64'(16'h4444));

        // SR illegal then set
        step("sr_bad", 1'b1, 1'b0, 2'b11, 4'b0001, 4'b0001);
        chk("sr_bad_q", 64'(a_dout), 64'(4'b0000));
        chk("sr_bad_err", 64'(a_sr), 64'(1));
        step("sr_set", 1'b1, 1'b0, 2'b11, 4'b0001, 4'b0000);
        chk("sr_set_q", 64'(a_dout[0]), 64'(1));
        chk("sr_set_err", 64'(a_sr), 64'(0));

        // saturation on the CNT_W=2 instance
        step("sat_init", 1'b1, 1'b1, 2'b00, 4'b0000, 4'b0000);
        s_cnt[0] = 2'd1; s_cnt[1] = 2'd2; s_cnt[2] = 2'd3; s_cnt[3] = 2'd3; s_cnt[4] = 2'd3;
        s_sat = 5'b00111;
        for (int n = 0; n < 5; n++) begin
            step("sat_run", 1'b1, 1'b0, 2'b01, 4'b0001, 4'b0000);
            chk("sat_cnt0", 64'(b_cnt[1:0]), 64'(s_cnt[n]));
            chk("sat_flag", 64'(b_sat), 64'(s_sat[n]));
        end
        step("sat_clr", 1'b1, 1'b1, 2'b01, 4'b0001, 4'b0000);
        chk("sat_clr_cnt", 64'(b_cnt), 64'(0));
        chk("sat_clr_flag", 64'(b_sat), 64'(0));
        chk("sat_clr_pulse", 64'(b_chg[0]), 64'(1));

        // enable low holds everything
        step("en_pre", 1'b1, 1'b0, 2'b00, 4'b0110, 4'b0000);
        for (int n = 0; n < 2; n++) begin
            step("en_off", 1'b0, 1'b0, 2'b01, 4'b1111, 4'b0000);
            chk("en_off_q", 64'(a_dout), 64'(4'b0110));
            chk("en_off_chg", 64'(a_chg), 64'(0));
        end

        // mode switch D -> T takes effect at the first edge it is present
        step("msw_d", 1'b1, 1'b0, 2'b00, 4'b0101, 4'b0000);
        chk("msw_d_q", 64'(a_dout), 64'(4'b0101));
        step("msw_t", 1'b1, 1'b0, 2'b01, 4'b0101, 4'b0000);
        chk("msw_t_q", 64'(a_dout), 64'(4'b0000));

        for (int n = 0; n < 400; n++) begin
            if (n % 100 == 57) mid_reset();
            step("rand", ($urandom_range(0, 7) != 0), ($urandom_range(0, 15) == 0),
                 2'($urandom_range(0, 3)), 4'($urandom), 4'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/ff_bank_cfg.md
Name: ff_bank_cfg

Overview:
- Parametrised bank of WIDTH independent single-bit storage cells; successor to the single T flip-flop exercise block.
- A runtime mode selects D, T, JK or SR behaviour for all cells.
- Adds per-cell change detection and saturating change counters, used by lab benches to check toggle activity without waveform inspection.
- Sits between stimulus logic and the observation/scoring logic in the lab designs.

Parameters:
WIDTH, 4, number of cells (1..32)
CNT_W, 4, width of each per-cell change counter (2..16)
RST_VAL, 0, reset value of data_out (WIDTH bits; bit i applies to cell i)

Ports:
clk  input  1  clock, rising edge active
rst_n  input  1  asynchronous reset, active-low
en  input  1  cell update enable; 0 = all cells hold
clr  input  1  synchronous clear of counters and sticky flag (cells unaffected)
mode  input  2  00 D, 01 T, 10 JK, 11 SR
data_in  input  WIDTH  D / T / J / S input per cell
aux_in  input  WIDTH  K (JK) / R (SR) per cell; ignored in D and T
data_out  output  WIDTH  cell state, registered
chg_pulse  output  WIDTH  one-cycle pulse: cell changed at the previous edge
chg_cnt  output  WIDTH*CNT_W  packed counters; cell i at [i*CNT_W +: CNT_W]
sr_err  output  1  one-cycle pulse: some cell had S=R=1 in SR mode at an enabled edge
sat_flag  output  1  sticky: some counter reached its maximum

Behaviour:
- Reset (rst_n=0, asynchronous, immediate): data_out=RST_VAL, chg_pulse=0, chg_cnt=0, sr_err=0, sat_flag=0. Reset has priority over all other inputs. Reset asserted mid-operation discards all state. The first edge after release behaves normally.
- Next state per cell, evaluated at a rising edge with en=1 (q = current, d = data_in[i], a = aux_in[i]):
  - D: q' = d
  - T: q' = q ^ d
  - JK: 00 hold, 01 q'=0, 10 q'=1, 11 q'=~q (J=d, K=a)
  - SR: 00 hold, 10 q'=1, 01 q'=0, 11 hold (illegal; sr_err asserted)
- en=0: all cells hold, chg_pulse=0, sr_err=0, counters unchanged.
- mode is sampled at the same edge as the data. A mode change takes effect at the first edge where the new value is present. There is no mode state machine.
- Latency: data_out updates one edge after the sampled inputs; chg_pulse and counters update at that same edge (chg_pulse[i] = q' != q).
- Counters:
  - chg_cnt[i] increments by 1 at each edge where cell i changes.
  - Saturates at 2^CNT_W-1; no wrap-around.
  - sat_flag is set at the edge where any counter reaches its maximum and stays set until clr or reset.
- clr=1 at an edge: all counters go to 0 and sat_flag goes to 0.
  - A change in the same cycle is not counted.
  - chg_pulse still reflects the change.
  - Cells still update per en/mode.
- sr_err is a pulse, high for exactly one cycle per offending edge; consecutive offending edges keep it high.
- All outputs are registered. There is no combinational path from inputs to outputs.

Test Plan:
- Reset: WIDTH=4, RST_VAL=4'b1010; assert rst_n=0 mid-clock-period -> data_out=1010 immediately; chg_cnt=0, sat_flag=0 before the next edge.
- T mode, data_in=4'b0001 for 3 edges starting from 0000:
  - data_out[0] sequence = 1,0,1
  - chg_pulse[0]=1 for 3 cycles; chg_cnt cell0=3, other cells 0.
- JK mode from 0000: J=1111,K=0000 -> 1111; then J=0000,K=1111 -> 0000; then J=K=1111 for 2 edges -> 1111, 0000; each cell's counter = 4.
- SR mode: S=0001,R=0001 -> data_out unchanged and sr_err=1 for 1 cycle; then S=0001,R=0 -> data_out[0]=1 and sr_err=0.
- Saturation, CNT_W=2: toggle cell0 for 5 edges -> counter 1,2,3,3,3; sat_flag=1 from the 3rd edge. Then clr=1 with T=0001 -> counter=0, sat_flag=0, chg_pulse[0]=1.
- en=0 in T mode with data_in=1111 for 2 edges -> data_out, counters unchanged and chg_pulse=0. Mode switch D->T between edges -> the new mode applies at the first edge it is present.
